mem_port_arbiter: RTL and testbench

- Shares the single byte-wide system memory between two requesters:
  - port 0, the CPU control unit's data accesses;
  - port 1, a secondary master (DMA/debug loader).
- Arbitrates, then sequences a 1-4 byte little-endian transfer as consecutive byte accesses, then returns a 32-bit result with a done pulse.
- Sits between the requesters and the memory's CS/WR/address/data pins.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_rr_arbiter_2.sv | 16 +
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port byte-memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MEM_CS_ON  = 1'b0;
  localparam logic MEM_CS_OFF = 1'b1;

  // Len field holds byte count minus one.
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Two-way tie breaker: fixed port-0 priority or alternate away from last winner.
module rr_arbiter_2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  input  logic i_fixed_prio,
  output logic o_winner
);

  always_comb begin
    o_winner = 1'b0;
    if (i_req0 && i_req1) o_winner = i_fixed_prio ? 1'b0 : ~i_rr_last;
    else if (i_req1)      o_winner = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto a byte-wide memory and sequences 1-4 byte
// little-endian transfers, returning a 32-bit result with a done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wr0,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [1:0]        i_len0,
  input  logic [1:0]        i_len1,
  input  logic [31:0]       i_wdata0,
  input  logic [31:0]       i_wdata1,
  output logic              o_grant0,
  output logic              o_grant1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_cs,
  output logic              o_mem_wr,
  input  logic [7:0]        i_mem_din,
  output logic [7:0]        o_mem_dout,
  output logic              o_busy
);

  state_t              r_state;
  logic                r_rr_last, r_owner, r_wr;
  logic [1:0]          r_len, r_idx;
  logic [31:0]         r_wdata, r_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_cs, r_mem_wr, r_done0, r_done1;
  logic [7:0]          r_mem_dout;

  logic                w_winner, w_any, w_grant, w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [1:0]          w_sel_len;
  logic [31:0]         w_sel_wdata;

  rr_arbiter_2 u_arb (
    .i_req0      (i_req0),
    .i_req1      (i_req1),
    .i_rr_last   (r_rr_last),
    .i_fixed_prio(FIXED_PRIO),
    .o_winner    (w_winner)
  );

  assign w_any       = i_req0 | i_req1;
  assign w_grant     = (r_state == ST_IDLE) && w_any;
  assign w_sel_wr    = w_winner ? i_wr1    : i_wr0;
  assign w_sel_addr  = w_winner ? i_addr1  : i_addr0;
  assign w_sel_len   = w_winner ? i_len1   : i_len0;
  assign w_sel_wdata = w_winner ? i_wdata1 : i_wdata0;

  // Memory pins are registered one cycle ahead so each XFER cycle presents
  // a stable byte access straight from flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rr_last  <= 1'b1;
      r_owner    <= 1'b0;
      r_wr       <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_cs   <= MEM_CS_OFF;
      r_mem_wr   <= 1'b0;
      r_mem_dout <= '0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_state    <= ST_XFER;
          r_owner    <= w_winner;
          r_rr_last  <= w_winner;
          r_wr       <= w_sel_wr;
          r_len      <= w_sel_len;
          r_wdata    <= w_sel_wdata;
          r_rdata    <= '0;
          r_idx      <= '0;
          r_mem_cs   <= MEM_CS_ON;
          r_mem_addr <= w_sel_addr;
          r_mem_wr   <= w_sel_wr;
          r_mem_dout <= w_sel_wr ? w_sel_wdata[7:0] : 8'h00;
        end
        ST_XFER: begin
          if (!r_wr) r_rdata[8*r_idx +: 8] <= i_mem_din;
          if (r_idx == r_len) begin
            r_state    <= ST_DONE;
            r_mem_cs   <= MEM_CS_OFF;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
            r_done0    <= ~r_owner;
            r_done1    <= r_owner;
          end else begin
            r_idx      <= r_idx + 2'd1;
            r_mem_addr <= r_mem_addr + 1'b1;
            r_mem_dout <= r_wr ? byte_sel(r_wdata, r_idx + 2'd1) : 8'h00;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant0   = w_grant & ~w_winner;
  assign o_grant1   = w_grant &  w_winner;
  assign o_done0    = r_done0;
  assign o_done1    = r_done1;
  assign o_rdata    = r_rdata;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_cs   = r_mem_cs;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_dout = r_mem_dout;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with access/result scoreboards.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 16;

  typedef struct { logic [AW-1:0] addr; logic wr; logic [7:0] data; } acc_t;
  typedef struct { logic port; logic [31:0] rdata; } res_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [1:0]    len0 = '0, len1 = '0;
  logic [31:0]   wdata0 = '0, wdata1 = '0;
  logic          grant0, grant1, done0, done1, mem_cs, mem_wr, busy;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;

  logic          f_req0 = 0, f_req1 = 0;
  logic          f_grant0, f_grant1, f_done0, f_done1, f_cs, f_wr, f_busy;
  logic [31:0]   f_rdata;
  logic [AW-1:0] f_addr;
  logic [7:0]    f_dout;

  logic [7:0]    mem [0:65535];
  acc_t          acc_q[$];
  res_t          res_q[$];
  int            vecs = 0, errs = 0, cs_lo = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
    .i_addr0(addr0), .i_addr1(addr1), .i_len0(len0), .i_len1(len1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_grant0(grant0), .o_grant1(grant1),
    .o_done0(done0), .o_done1(done1), .o_rdata(rdata), .o_mem_addr(mem_addr),
    .o_mem_cs(mem_cs), .o_mem_wr(mem_wr), .i_mem_din(mem_din), .o_mem_dout(mem_dout),
    .o_busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) dut_fix (
    .i_clk(clk), .i_rst(rst), .i_req0(f_req0), .i_req1(f_req1), .i_wr0(1'b0), .i_wr1(1'b0),
    .i_addr0(16'h0000), .i_addr1(16'h0001), .i_len0(LEN_1B), .i_len1(LEN_1B),
    .i_wdata0(32'h0), .i_wdata1(32'h0), .o_grant0(f_grant0), .o_grant1(f_grant1),
    .o_done0(f_done0), .o_done1(f_done1), .o_rdata(f_rdata), .o_mem_addr(f_addr),
    .o_mem_cs(f_cs), .o_mem_wr(f_wr), .i_mem_din(8'h3C), .o_mem_dout(f_dout),
    .o_busy(f_busy)
  );

  assign mem_din = mem[mem_addr];

  always @(posedge clk)
    if (mem_cs == 1'b0 && mem_wr) mem[mem_addr] <= mem_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected memory accesses and result for a request, from the bench memory image.
  task automatic push_exp(input logic p, input logic wr, input logic [AW-1:0] a,
                          input logic [1:0] l, input logic [31:0] wd);
    res_t r;
    logic [AW-1:0] ai;
    r.port = p; r.rdata = '0;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + AW'(i);
      acc_q.push_back('{addr: ai, wr: wr, data: wd[8*i +: 8]});
      if (!wr) r.rdata[8*i +: 8] = mem[ai];
    end
    res_q.push_back(r);
  endtask

  task automatic issue(input logic p, input logic wr, input logic [AW-1:0] a,
                       input logic [1:0] l, input logic [31:0] wd);
    push_exp(p, wr, a, l, wd);
    if (!p) begin wr0 = wr; addr0 = a; len0 = l; wdata0 = wd; req0 = 1; end
    else    begin wr1 = wr; addr1 = a; len1 = l; wdata1 = wd; req1 = 1; end
    #1;
    chk(p ? "grant1_cyc0" : "grant0_cyc0", {31'b0, p ? grant1 : grant0}, 32'd1);
  endtask

  task automatic wait_done(input logic p, input int exp_cyc);
    int k;
    bit seen;
    seen = 0;
    for (k = 1; k <= exp_cyc + 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin if (p) req1 = 0; else req0 = 0; end
      if (p ? done1 : done0) begin seen = 1; break; end
    end
    chk("done_latency", seen ? k : -1, exp_cyc);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; f_req0 = 0; f_req1 = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
  endtask

  // Scoreboard side: every selected byte access and every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cs == 1'b0) begin
        acc_t e;
        cs_lo++;
        if (acc_q.size() == 0) chk("unexpected_access", {16'b0, mem_addr}, 32'hFFFFFFFF);
        else begin
          e = acc_q.pop_front();
          chk("mem_addr", {16'b0, mem_addr}, {16'b0, e.addr});
          chk("mem_wr", {31'b0, mem_wr}, {31'b0, e.wr});
          if (e.wr) chk("mem_dout", {24'b0, mem_dout}, {24'b0, e.data});
        end
      end
      if (done0 || done1) begin
        res_t r;
        chk("done_onehot", {31'b0, done0 & done1}, 32'd0);
        if (res_q.size() == 0) chk("unexpected_done", rdata, 32'hFFFFFFFF);
        else begin
          r = res_q.pop_front();
          chk("done_port", {31'b0, done1}, {31'b0, r.port});
          chk("rdata", rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    int ng, cyc, n0;
    int gport[4], gcyc[4];
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD; mem[16'h0100] = 8'h7F;
    mem[16'h0200] = 8'h5A; mem[16'h0300] = 8'hA5;

    // Reset state
    #12;
    chk("rst_cs_during", {31'b0, mem_cs}, 32'd1);
    do_reset();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cs", {31'b0, mem_cs}, 32'd1);
    chk("rst_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_dout", {24'b0, mem_dout}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {30'b0, done1, done0}, 32'd0);

    // 2-byte read by port 0
    issue(1'b0, 1'b0, 16'h0010, LEN_2B, 32'h0);
    wait_done(1'b0, 3);
    repeat (2) @(posedge clk);
    #1 chk("rdata_held", rdata, 32'h0000CDAB);

    // 4-byte write by port 1 wrapping past 0xFFFF
    issue(1'b1, 1'b1, 16'hFFFE, LEN_4B, 32'h11223344);
    wait_done(1'b1, 5);
    chk("wmem_fffe", {24'b0, mem[16'hFFFE]}, 32'h44);
    chk("wmem_ffff", {24'b0, mem[16'hFFFF]}, 32'h33);
    chk("wmem_0000", {24'b0, mem[16'h0000]}, 32'h22);
    chk("wmem_0001", {24'b0, mem[16'h0001]}, 32'h11);
    @(posedge clk); #1;

    // Round-robin under continuous contention from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin gport[i] = -1; gcyc[i] = -1; end
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 16'h0200, LEN_1B, 32'h0);
      push_exp(1'b1, 1'b0, 16'h0300, LEN_1B, 32'h0);
    end
    wr0 = 0; addr0 = 16'h0200; len0 = LEN_1B;
    wr1 = 0; addr1 = 16'h0300; len1 = LEN_1B;
    req0 = 1; req1 = 1; #1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      if (grant0 || grant1) begin gport[ng] = int'(grant1); gcyc[ng] = cyc; ng++; end
      if (ng < 4) begin @(posedge clk); #1; cyc++; end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    chk("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_port", gport[i], i % 2);
      chk("rr_grant_cycle", gcyc[i], 3 * i);
    end
    repeat (4) @(posedge clk);
    #1;

    // Fixed priority instance: port 0 keeps winning
    f_req0 = 1; f_req1 = 1; #1;
    ng = 0; cyc = 0;
    while (ng < 3 && cyc < 30) begin
      if (f_grant1) chk("fix_grant1", 32'd1, 32'd0);
      if (f_grant0) ng++;
      if (ng < 3) begin @(posedge clk); #1; cyc++; end
    end
    chk("fix_grant0_count", ng, 3);
    chk("fix_last_cycle", cyc, 6);
    @(posedge clk); #1;
    f_req0 = 0; f_req1 = 0;
    repeat (4) @(posedge clk);
    #1;

    // Port 1 requests during port 0's transfer
    issue(1'b0, 1'b0, 16'h0010, LEN_2B, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req0 = 0;
        push_exp(1'b1, 1'b0, 16'h0300, LEN_1B, 32'h0);
        wr1 = 0; addr1 = 16'h0300; len1 = LEN_1B; req1 = 1;
        #1;
      end
      chk("pend_grant1", {31'b0, grant1}, {31'b0, k == 4});
      chk("pend_done0", {31'b0, done0}, {31'b0, k == 3});
      if (k == 5) req1 = 0;
    end

    // Reset during a 4-byte write, after byte 1
    issue(1'b0, 1'b1, 16'h0400, LEN_4B, 32'hDEADBEEF);
    @(posedge clk); #1; req0 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; #1;
    chk("midrst_cs", {31'b0, mem_cs}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_bytes_done", acc_q.size(), 2);
    acc_q.delete(); res_q.delete();
    chk("midrst_mem400", {24'b0, mem[16'h0400]}, 32'hEF);
    chk("midrst_mem401", {24'b0, mem[16'h0401]}, 32'hBE);
    chk("midrst_mem402", {24'b0, mem[16'h0402]}, 32'h00);
    @(posedge clk); #1; rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy) chk("midrst_quiet", {29'b0, busy, done1, done0}, 32'd0);
    end

    // Single-byte read
    n0 = cs_lo;
    issue(1'b0, 1'b0, 16'h0100, LEN_1B, 32'h0);
    wait_done(1'b0, 2);
    @(posedge clk); #1;
    chk("len0_cs_cycles", cs_lo - n0, 1);
    chk("sb_empty", acc_q.size() + res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
